// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b - bin, LSB first, one full-subtractor cell and a registered borrow.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, r_nxt;
    logic [WIDTH-2:0] r_sr;
    logic [CW-1:0]    cnt;
    logic             br, x, y, d, br_nxt, accept, last;
    always_comb begin
        x      = a_sr[0];
        y      = b_sr[0];
        d      = x ^ y ^ br;
        br_nxt = (~x & y) | (~(x ^ y) & br);
        r_nxt  = {d, r_sr};
        accept = (state == IDLE || state == DONE) && start;
        last   = (state == RUN) && (cnt == LAST);
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end
    // r_sr keeps only the low WIDTH-1 result bits; the final bit joins them at completion
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            if (accept) begin
                a_sr <= a;
                b_sr <= b;
                br   <= bin;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= r_nxt[WIDTH-1:1];
                br   <= br_nxt;
                cnt  <= cnt + 1'b1;
            end
            if (last) begin
                diff <= r_nxt;
                bout <= br_nxt;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8 and WIDTH=13.
module tb_serial_sub;
    typedef struct {
        logic [12:0] d;
        logic        bo;
        int          acc;
    } exp_t;
    logic        clk = 1'b0, rst;
    logic        start8, bin8, busy8, done8, bout8;
    logic [7:0]  a8, b8, diff8;
    logic        start13, bin13, busy13, done13, bout13;
    logic [12:0] a13, b13, diff13;
    int          cyc = 0, checks = 0, errors = 0;
    exp_t        q8[$], q13[$];
    serial_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );
    serial_sub #(.WIDTH(13)) u13 (
        .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .bin(bin13),
        .busy(busy13), .done(done13), .diff(diff13), .bout(bout13)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) chk("unexpected_done8", 1, 0);
            else begin
                e = q8.pop_front();
                chk("result8", {bout8, diff8}, {e.bo, e.d[7:0]});
                chk("latency8", cyc - e.acc, 8);
            end
        end
        if (done13) begin
            if (q13.size() == 0) chk("unexpected_done13", 1, 0);
            else begin
                e = q13.pop_front();
                chk("result13", {bout13, diff13}, {e.bo, e.d});
                chk("latency13", cyc - e.acc, 13);
            end
        end
    end
    task automatic wait_empty(input int k);
        int n = 0;
        while ((k == 0 ? q8.size() : q13.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(k == 0 ? "drain8" : "drain13", k == 0 ? q8.size() : q13.size(), 0);
    endtask
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          input logic [7:0] ed, input logic eb);
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        q8.push_back('{d: {5'd0, ed}, bo: eb, acc: cyc + 1});
    endtask
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic [7:0] ed, input logic eb);
        issue8(av, bv, bi, ed, eb);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hC3; b8 = 8'h3C; bin8 = ~bi;
        wait_empty(0);
    endtask
    task automatic run13(input logic [12:0] av, input logic [12:0] bv, input logic bi);
        logic [13:0] r;
        r = {1'b0, av} - {1'b0, bv} - {13'd0, bi};
        @(negedge clk);
        a13 = av; b13 = bv; bin13 = bi; start13 = 1'b1;
        q13.push_back('{d: r[12:0], bo: r[13], acc: cyc + 1});
        @(negedge clk);
        start13 = 1'b0; a13 = ~av; b13 = ~bv; bin13 = ~bi;
        wait_empty(1);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        int nb, nd;
        logic [8:0] r9;
        rst = 1'b1;
        {start8, bin8, a8, b8} = '0;
        {start13, bin13, a13, b13} = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_diff8", diff8, 0);
        chk("rst_bout8", bout8, 0);
        chk("rst_busy13", busy13, 0);
        chk("rst_done13", done13, 0);
        chk("rst_diff13", diff13, 0);
        chk("rst_bout13", bout13, 0);
        rst = 1'b0;
        // simple subtract with busy/done timing
        issue8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            nb += int'(busy8);
            @(negedge clk);
        end
        chk("busy_cycles", nb, 8);
        chk("done_at_8", done8, 1);
        chk("busy_low_in_done", busy8, 0);
        wait_empty(0);
        // underflow and borrow chains
        run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        run8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
        // start during RUN cycles 2 and 5 must be ignored
        issue8(8'h10, 8'h03, 1'b0, 8'h0D, 1'b0);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        @(negedge clk); start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        @(negedge clk); start8 = 1'b0;
        wait_empty(0);
        repeat (12) @(negedge clk);
        // start held high: three back-to-back results, 9 cycles apart
        issue8(8'h34, 8'h12, 1'b0, 8'h22, 1'b0);
        nb = 0;
        nd = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            nb += int'(busy8);
            nd += int'(done8);
            if (i == 0) begin
                a8 = 8'h12; b8 = 8'h34; bin8 = 1'b0;
                q8.push_back('{d: 13'h0DE, bo: 1'b1, acc: cyc + 9});
            end
            if (i == 9) begin
                a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
                q8.push_back('{d: 13'h054, bo: 1'b0, acc: cyc + 9});
            end
            if (i == 18) start8 = 1'b0;
        end
        chk("hold_busy_cycles", nb, 24);
        chk("hold_done_pulses", nd, 3);
        wait_empty(0);
        // reset on the 4th RUN cycle aborts silently
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy8, 0);
        chk("abort_diff", diff8, 0);
        chk("abort_bout", bout8, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        // reset wins over a simultaneous start
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        chk("rst_start_busy", busy8, 0);
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", busy8, 0);
        run8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        // random operands against a WIDTH+1 bit reference
        fork
            for (int i = 0; i < 1000; i++) begin
                logic [7:0] ra, rb;
                logic       rc;
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                r9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rc};
                run8(ra, rb, rc, r9[7:0], r9[8]);
            end
            for (int j = 0; j < 1000; j++)
                run13(13'($urandom), 13'($urandom), 1'($urandom));
        join
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
